mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative signed 32-bit multiply/divide unit in the multicycle datapath, directly downstream of the ALU operand muxes (source A and the SrcB mux). The control FSM pulses `start` with the operation select. The unit latches the two mux outputs and iterates one bit per clock. It writes the 64-bit product, or the quotient and remainder, into the HI/LO registers and signals `done`. The control FSM holds in a wait state while `busy` is high.

## Interface

Parameters:
- `WIDTH`, 32, operand width. HI and LO are each `WIDTH` bits. The iteration count equals `WIDTH`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request pulse. Sampled only in IDLE.
- `op`, input, 1: 0 = signed multiply (MULT), 1 = signed divide (DIV). Sampled with `start`.
- `a`, input, WIDTH: operand A (multiplicand / dividend), from the source A mux.
- `b`, input, WIDTH: operand B (multiplier / divisor), from the SrcB mux.
- `hi`, output, WIDTH: MULT gives product[63:32]; DIV gives the remainder.
- `lo`, output, WIDTH: MULT gives product[31:0]; DIV gives the quotient.
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle pulse when results are valid.
- `div_zero`, output, 1: set when a DIV has a zero divisor.

## Operation

**Reset values:** state = IDLE; `hi` = 0; `lo` = 0; `busy` = 0; `done` = 0; `div_zero` = 0. Reset aborts any operation in flight with no partial write to HI/LO.

**FSM states:** IDLE, MULT, DIV, FIX.
- IDLE + `start` + `op`=0 -> MULT.
- IDLE + `start` + `op`=1 + `b`≠0 -> DIV.
- IDLE + `start` + `op`=1 + `b`=0 -> IDLE. Pulse `done`, set `div_zero`, leave HI/LO unchanged.
- MULT or DIV, after WIDTH iterations -> FIX.
- FIX -> IDLE. Write HI/LO and pulse `done`.

**Operand capture:**
- `a`, `b` and `op` are registered on the accepting edge.
- Later changes on the inputs (mux select changes) do not affect the result.

**MULT:**
- Radix-2 Booth algorithm on a 2·WIDTH+1-bit accumulator, one bit per cycle.
- Result is the exact signed 64-bit product, with no overflow.

**DIV:**
- Restoring division on the magnitudes |a| and |b|.
- FIX applies signs:
  - quotient is negated when the operand signs differ, so it truncates toward zero;
  - remainder takes the sign of the dividend.
- −2^31 / −1 wraps: `lo` = 0x8000_0000, `hi` = 0.

**Result holding and flags:**
- HI/LO hold their value until the next completed operation.
- `div_zero` stays high until the next accepted `start`, which clears it.

**Start while busy:**
- `start` is ignored while `busy` = 1, with no queueing.
- `start` is accepted in the same cycle that `done` is high, because the FSM is already in IDLE.

## Timing

- Take the accepting edge as edge k.
- `busy` is high from edge k until edge k+WIDTH+1. With WIDTH = 32, it is high for 33 cycles.
- Iterations run on edges k+1 through k+WIDTH.
- HI/LO are written on edge k+WIDTH+1. `done` is high for exactly one cycle after that edge, when `busy` is 0.
- Total latency from `start` to `done` is WIDTH+1 clocks (33).
- Divide by zero: `done` and `div_zero` are high in the cycle after edge k, and `busy` never rises.
- `done`, `busy`, `hi`, `lo` and `div_zero` are all registered outputs, with no combinational path from the inputs.
- Reset asserted mid-operation: on the next edge all outputs return to their reset values, and `done` does not pulse.

## Test plan

- MULT `a`=7, `b`=−3 -> after 33 clocks `done`=1, `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB; `busy` high for exactly 33 cycles.
- MULT `a`=`b`=0x8000_0000 -> `hi`=0x4000_0000, `lo`=0. MULT 0xFFFF_FFFF × 0xFFFF_FFFF -> `hi`=0, `lo`=1.
- DIV −7/2 -> `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. DIV 7/−2 -> `lo`=0xFFFF_FFFD, `hi`=1. DIV 0x8000_0000/0xFFFF_FFFF -> `lo`=0x8000_0000, `hi`=0.
- DIV 5/0 with HI/LO preloaded to 0x1234/0x5678:
  - `done` and `div_zero` are high one clock later, `busy` stays 0, and HI/LO are unchanged.
  - A following MULT clears `div_zero`.
- Pulse `start` at cycle 10 of a running MULT with different operands -> ignored; the result matches the original operands. Then issue a new `start` in the `done` cycle -> accepted, and `busy` rises on the next edge.
- Assert `reset` at iteration 15 of a DIV -> next cycle `hi`=`lo`=0, `busy`=0, and `done` never pulses. The next operation completes correctly.

Source files
------------

// File: rtl/mult_div_if.sv
// Operand/result bundle between the multicycle control path and the multiply/divide unit.
// The control FSM is the master. The unit is the slave.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit feeding HI/LO.
// It retires one bit per clock. A final FIX cycle applies the signs and writes HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);
  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_op;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_a_in_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_div_lo;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_rem_next;
  logic             w_q_bit;

  // Next-step datapath for Booth, restoring divide and final sign fix-up
  always_comb begin
    w_a_in_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
    w_b_mag    = r_b[WIDTH-1] ? -r_b : r_b;

    // Booth sum is one bit wider so that adding or subtracting -2^(WIDTH-1) cannot overflow
    w_booth_sum = {r_acc[AW-1], r_acc[AW-1:WIDTH+1]};
    case (r_acc[1:0])
      2'b01:   w_booth_sum = {r_acc[AW-1], r_acc[AW-1:WIDTH+1]} + {r_a[WIDTH-1], r_a};
      2'b10:   w_booth_sum = {r_acc[AW-1], r_acc[AW-1:WIDTH+1]} - {r_a[WIDTH-1], r_a};
      default: w_booth_sum = {r_acc[AW-1], r_acc[AW-1:WIDTH+1]};
    endcase

    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, w_b_mag};
    w_q_bit  = ~w_trial[WIDTH];
    if (w_q_bit) begin
      w_rem_next = w_trial;
    end else begin
      w_rem_next = w_rem_sh;
    end

    w_quo    = r_acc[WIDTH-1:0];
    w_rem    = r_acc[2*WIDTH-1:WIDTH];
    w_div_lo = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_quo : w_quo;
    w_div_hi = r_a[WIDTH-1] ? -w_rem : w_rem;
  end

  // Control FSM, iteration state and registered HI/LO/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= {AW{1'b0}};
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_op       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= {CW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_div_zero <= 1'b0;
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_op       <= bus.op;
            r_cnt      <= {CW{1'b0}};
            if (!bus.op) begin
              r_acc   <= {{WIDTH{1'b0}}, bus.b, 1'b0};
              r_busy  <= 1'b1;
              r_state <= S_MULT;
            end else if (bus.b == {WIDTH{1'b0}}) begin
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_acc   <= {{(WIDTH+1){1'b0}}, w_a_in_mag};
              r_busy  <= 1'b1;
              r_state <= S_DIV;
            end
          end
        end
        S_MULT: begin
          r_acc <= {w_booth_sum, r_acc[WIDTH:1]};
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV: begin
          r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_q_bit};
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (r_op) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end else begin
            r_hi <= r_acc[AW-1:WIDTH+1];
            r_lo <= r_acc[WIDTH:1];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit.
// Results are predicted from plain signed 64-bit arithmetic.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: signed product, or quotient truncated toward zero with remainder signed like the dividend
  function automatic void ref_model(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                    output logic [31:0] exp_hi, output logic [31:0] exp_lo);
    longint sa;
    longint sb;
    longint res;
    longint rem;
    sa = longint'($signed(a_i));
    sb = longint'($signed(b_i));
    if (!op_i) begin
      res    = sa * sb;
      exp_hi = res[63:32];
      exp_lo = res[31:0];
    end else begin
      res    = sa / sb;
      rem    = sa % sb;
      exp_hi = rem[31:0];
      exp_lo = res[31:0];
    end
  endfunction

  // Called right after a negedge. Returns at the negedge where done is seen.
  task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input int disturb_at);
    int   busy_cnt;
    logic got_done;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    busy_cnt  = 0;
    got_done  = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.a  = $urandom;
      bus.b  = $urandom;
      bus.op = ~op_i;
      @(negedge clk);
      bus.start = (c == disturb_at);
      if (c == 0) check_eq("busy_rise", {63'd0, bus.busy}, 64'd1);
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    bus.start = 1'b0;
    ref_model(op_i, a_i, b_i, exp_hi, exp_lo);
    check_eq("busy_cycles", 64'(busy_cnt), 64'd33);
    check_eq("done_seen", {63'd0, got_done}, 64'd1);
    check_eq("busy_at_done", {63'd0, bus.busy}, 64'd0);
    check_eq("div_zero_clr", {63'd0, bus.div_zero}, 64'd0);
    check_eq(op_i ? "div_hi" : "mult_hi", {32'd0, bus.hi}, {32'd0, exp_hi});
    check_eq(op_i ? "div_lo" : "mult_lo", {32'd0, bus.lo}, {32'd0, exp_lo});
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw_done;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rop;
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("rst_lo", {32'd0, bus.lo}, 64'd0);
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_done", {63'd0, bus.done}, 64'd0);
    check_eq("rst_dz", {63'd0, bus.div_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    check_eq("mult_7x-3_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check_eq("mult_7x-3_lo", {32'd0, bus.lo}, 64'hFFFF_FFEB);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    check_eq("mult_min_hi", {32'd0, bus.hi}, 64'h4000_0000);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check_eq("mult_m1_lo", {32'd0, bus.lo}, 64'd1);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1);
    check_eq("div_7_m2_hi", {32'd0, bus.hi}, 64'd1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check_eq("div_wrap_lo", {32'd0, bus.lo}, 64'h8000_0000);

    // Preload HI=0x1234 / LO=0x5678, then divide by zero
    run_op(1'b1, 32'h5678_1234, 32'h0001_0000, -1);
    check_eq("preload_hi", {32'd0, bus.hi}, 64'h1234);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd5;
    bus.b     = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("dz_done", {63'd0, bus.done}, 64'd1);
    check_eq("dz_flag", {63'd0, bus.div_zero}, 64'd1);
    check_eq("dz_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("dz_hi", {32'd0, bus.hi}, {32'd0, model_hi});
    check_eq("dz_lo", {32'd0, bus.lo}, {32'd0, model_lo});
    @(negedge clk);
    check_eq("dz_done_once", {63'd0, bus.done}, 64'd0);
    check_eq("dz_flag_hold", {63'd0, bus.div_zero}, 64'd1);
    check_eq("dz_busy_hold", {63'd0, bus.busy}, 64'd0);
    run_op(1'b0, 32'd12345, 32'hFFFF_0001, -1);

    // Start mid-operation is ignored; the next start lands in the done cycle
    run_op(1'b0, 32'h1357_9BDF, 32'hF0F0_1234, 10);
    run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, 10);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, -1);

    // Reset at iteration 15 of a DIV
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'h7654_3210;
    bus.b     = 32'h0000_0011;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstmid_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("rstmid_lo", {32'd0, bus.lo}, 64'd0);
    check_eq("rstmid_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rstmid_done", {63'd0, bus.done}, 64'd0);
    reset    = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check_eq("rstmid_no_done", {63'd0, saw_done}, 64'd0);
    check_eq("rstmid_hold_lo", {32'd0, bus.lo}, {32'd0, model_lo});
    run_op(1'b1, 32'h7654_3210, 32'h0000_0011, -1);

    for (int it = 0; it < 24; it++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      if ((it % 3) == 0) rb = rb >> $urandom_range(0, 31);
      if ((it % 4) == 1) ra = ra >> $urandom_range(0, 31);
      if (rop && (rb == 32'd0)) rb = 32'd1;
      run_op(rop, ra, rb, ((it % 5) == 2) ? 7 : -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
